// File: rtl/cache_arbiter_if.sv
// -----------------------------------------------------------------------------
// cache_arbiter_if
// Bundle of every request/response signal between the two caches, the
// arbiter and the physical-memory port.
//
//   I-cache side : icache_read, icache_address   -> arbiter
//                  icache_rdata, icache_resp     <- arbiter
//   D-cache side : dcache_read, dcache_write,
//                  dcache_address, dcache_wdata  -> arbiter
//                  dcache_rdata, dcache_resp     <- arbiter
//   Memory side  : pmem_read, pmem_write,
//                  pmem_address, pmem_wdata      <- arbiter
//                  pmem_rdata, pmem_resp         -> arbiter
//
// Modports:
//   slave  - the arbiter's view (cache requests and memory replies in)
//   master - the environment's view (drives the caches and the memory)
// -----------------------------------------------------------------------------
interface cache_arbiter_if #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
);
    // I-cache
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    // D-cache
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    // Physical memory
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport slave (
        input  icache_read, icache_address,
        output icache_rdata, icache_resp,
        input  dcache_read, dcache_write, dcache_address, dcache_wdata,
        output dcache_rdata, dcache_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output icache_read, icache_address,
        input  icache_rdata, icache_resp,
        output dcache_read, dcache_write, dcache_address, dcache_wdata,
        input  dcache_rdata, dcache_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
// Round-robin arbiter granting the single physical-memory port to either the
// I-cache or the D-cache. A grant latches address, write data and operation
// into holding registers which drive memory until pmem_resp; the response and
// line are then handed to the winning cache only, in the same cycle.
//
// Ports:
//   clk     - sole clock, all state on posedge
//   rst     - synchronous active-high reset
//   io_arb  - cache_arbiter_if.slave carrying both cache ports and the
//             memory port
// -----------------------------------------------------------------------------
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_arbiter_if.slave         io_arb
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_I_BUSY = 2'd1,
        ST_D_BUSY = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_last_d;     // 1 when the D-cache was granted last
    logic              r_op_write;   // latched operation: 1 = write-back
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;

    logic              w_d_req;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_busy;

    // A D-cache write or read both count as a request; write wins an illegal
    // read+write combination when the op is latched below.
    assign w_d_req = io_arb.dcache_read | io_arb.dcache_write;
    assign w_busy  = (r_state != ST_IDLE);

    // Next-state and grant decode; cache inputs only matter in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_i   = 1'b0;
        w_grant_d   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // On contention the side not served last wins.
                if (w_d_req && (!io_arb.icache_read || !r_last_d)) begin
                    w_grant_d   = 1'b1;
                    w_state_nxt = ST_D_BUSY;
                end else if (io_arb.icache_read) begin
                    w_grant_i   = 1'b1;
                    w_state_nxt = ST_I_BUSY;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_I_BUSY: begin
                if (io_arb.pmem_resp) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_I_BUSY;
                end
            end
            ST_D_BUSY: begin
                if (io_arb.pmem_resp) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_D_BUSY;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers and round-robin pointer, loaded only on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_grant_d) begin
            r_last_d   <= 1'b1;
            r_op_write <= io_arb.dcache_write;
            r_addr     <= io_arb.dcache_address;
            r_wdata    <= io_arb.dcache_wdata;
        end else if (w_grant_i) begin
            r_last_d   <= 1'b0;
            r_op_write <= 1'b0;
            r_addr     <= io_arb.icache_address;
            r_wdata    <= '0;
        end else begin
            r_last_d   <= r_last_d;
            r_op_write <= r_op_write;
            r_addr     <= r_addr;
            r_wdata    <= r_wdata;
        end
    end

    // Memory side: strobes are a pure decode of registered state, so they
    // rise the cycle after the grant and drop the cycle after pmem_resp.
    assign io_arb.pmem_read    = w_busy & ~r_op_write;
    assign io_arb.pmem_write   = w_busy &  r_op_write;
    assign io_arb.pmem_address = r_addr;
    assign io_arb.pmem_wdata   = r_wdata;

    // Cache side: the line is broadcast, the resp pulse qualifies it and is
    // passed through combinationally to the owner only. A pmem_resp seen in
    // IDLE matches neither BUSY state and is therefore dropped.
    assign io_arb.icache_rdata = io_arb.pmem_rdata;
    assign io_arb.dcache_rdata = io_arb.pmem_rdata;
    assign io_arb.icache_resp  = (r_state == ST_I_BUSY) & io_arb.pmem_resp;
    assign io_arb.dcache_resp  = (r_state == ST_D_BUSY) & io_arb.pmem_resp;

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
// Directed bench: expected memory transactions are queued when a request is
// raised and popped when the arbiter presents the next memory strobe.
// Inputs change on the falling edge; outputs are sampled on the falling edge
// or 1 time unit after a falling-edge change.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cache_arbiter_if #(.LINE_W(LW), .ADDR_W(AW)) bus ();

    cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_arb (bus.slave)
    );

    typedef struct {
        logic          is_d;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] wdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic is_d, input logic wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wdata);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = addr;
        e.wdata = wdata;
        sb.push_back(e);
    endtask

    // Called in the falling edge where the winning request is visible to the
    // next rising edge. Expects the strobe exactly one cycle later, optionally
    // holds memory busy for extra cycles (and mutates I inputs), then returns
    // the response and checks routing. Returns in the IDLE cycle after resp.
    task automatic serve(input logic [LW-1:0] rd, input int hold, input bit mutate_i);
        exp_t e;
        tick();
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        if (mutate_i) begin
            bus.icache_address = 32'hFFFF_FFC0;
            bus.icache_read    = 1'b0;
        end
        for (int k = 0; k <= hold; k++) begin
            if (k > 0) tick();
            chk("pmem_read", {255'd0, bus.pmem_read}, {255'd0, ~e.wr});
            chk("pmem_write", {255'd0, bus.pmem_write}, {255'd0, e.wr});
            chk("pmem_address", {224'd0, bus.pmem_address}, {224'd0, e.addr});
            if (e.wr) chk("pmem_wdata", bus.pmem_wdata, e.wdata);
            chk("icache_resp_pre", {255'd0, bus.icache_resp}, {LW{1'b0}});
            chk("dcache_resp_pre", {255'd0, bus.dcache_resp}, {LW{1'b0}});
        end
        bus.pmem_rdata = rd;
        bus.pmem_resp  = 1'b1;
        #1;
        chk("icache_resp", {255'd0, bus.icache_resp}, {255'd0, ~e.is_d});
        chk("dcache_resp", {255'd0, bus.dcache_resp}, {255'd0, e.is_d});
        if (e.is_d) chk("dcache_rdata", bus.dcache_rdata, rd);
        else        chk("icache_rdata", bus.icache_rdata, rd);
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        chk("strobe_after_resp", {254'd0, bus.pmem_read, bus.pmem_write}, {LW{1'b0}});
    endtask

    initial begin
        logic [LW-1:0] pat_a5;
        logic [LW-1:0] pat_db;
        pat_a5 = {32{8'hA5}};
        pat_db = {8{32'hDEAD_BEEF}};

        rst                = 1'b1;
        bus.icache_read    = 1'b0;
        bus.icache_address = 32'd0;
        bus.dcache_read    = 1'b0;
        bus.dcache_write   = 1'b0;
        bus.dcache_address = 32'd0;
        bus.dcache_wdata   = {LW{1'b0}};
        bus.pmem_rdata     = {LW{1'b0}};
        bus.pmem_resp      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_pmem_read", {255'd0, bus.pmem_read}, {LW{1'b0}});
        chk("rst_pmem_write", {255'd0, bus.pmem_write}, {LW{1'b0}});
        chk("rst_pmem_address", {224'd0, bus.pmem_address}, {LW{1'b0}});
        chk("rst_pmem_wdata", bus.pmem_wdata, {LW{1'b0}});
        chk("rst_icache_resp", {255'd0, bus.icache_resp}, {LW{1'b0}});
        chk("rst_dcache_resp", {255'd0, bus.dcache_resp}, {LW{1'b0}});

        // I-only fill, memory held busy two extra cycles
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_1000;
        push(1'b0, 1'b0, 32'h0000_1000, {LW{1'b0}});
        serve(pat_a5, 2, 1'b0);
        bus.icache_read = 1'b0;

        // Fresh reset, then simultaneous requests: D first, then I with its
        // inputs changed after the grant
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_0100;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0200;
        push(1'b1, 1'b0, 32'h0000_0200, {LW{1'b0}});
        push(1'b0, 1'b0, 32'h0000_0100, {LW{1'b0}});
        serve({LW{1'b1}}, 0, 1'b0);
        bus.dcache_read = 1'b0;
        serve({64{4'h3}}, 3, 1'b1);

        // Both held high continuously: strict D, I, D, I alternation
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_0100;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0200;
        push(1'b1, 1'b0, 32'h0000_0200, {LW{1'b0}});
        push(1'b0, 1'b0, 32'h0000_0100, {LW{1'b0}});
        push(1'b1, 1'b0, 32'h0000_0200, {LW{1'b0}});
        push(1'b0, 1'b0, 32'h0000_0100, {LW{1'b0}});
        serve({64{4'h1}}, 0, 1'b0);
        serve({64{4'h2}}, 1, 1'b0);
        serve({64{4'h4}}, 0, 1'b0);
        serve({64{4'h8}}, 0, 1'b0);
        bus.icache_read = 1'b0;
        bus.dcache_read = 1'b0;

        // D write-back
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 32'h0000_8000;
        bus.dcache_wdata   = pat_db;
        push(1'b1, 1'b1, 32'h0000_8000, pat_db);
        serve({LW{1'b0}}, 1, 1'b0);
        bus.dcache_write = 1'b0;

        // D read aborted by reset two cycles in (D was served last, so only
        // the reset can make D win the following contention)
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0300;
        tick();
        chk("abort_strobe_up", {255'd0, bus.pmem_read}, {{255{1'b0}}, 1'b1});
        tick();
        rst             = 1'b1;
        bus.dcache_read = 1'b0;
        tick();
        rst = 1'b0;
        chk("abort_strobes", {254'd0, bus.pmem_read, bus.pmem_write}, {LW{1'b0}});
        chk("abort_dresp", {255'd0, bus.dcache_resp}, {LW{1'b0}});
        tick();
        chk("abort_idle", {254'd0, bus.pmem_read, bus.pmem_write}, {LW{1'b0}});
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_0500;
        bus.dcache_read    = 1'b1;
        bus.dcache_address = 32'h0000_0400;
        push(1'b1, 1'b0, 32'h0000_0400, {LW{1'b0}});
        push(1'b0, 1'b0, 32'h0000_0500, {LW{1'b0}});
        serve({64{4'h5}}, 0, 1'b0);
        bus.dcache_read = 1'b0;
        serve({64{4'h6}}, 0, 1'b0);
        bus.icache_read = 1'b0;

        // Illegal read+write: write wins
        bus.dcache_read    = 1'b1;
        bus.dcache_write   = 1'b1;
        bus.dcache_address = 32'h0000_9000;
        bus.dcache_wdata   = {LW{1'b1}} ^ pat_db;
        push(1'b1, 1'b1, 32'h0000_9000, {LW{1'b1}} ^ pat_db);
        serve({LW{1'b0}}, 0, 1'b0);
        bus.dcache_read  = 1'b0;
        bus.dcache_write = 1'b0;

        // Spurious pmem_resp in IDLE
        bus.pmem_resp  = 1'b1;
        bus.pmem_rdata = pat_a5;
        #1;
        chk("spur_iresp", {255'd0, bus.icache_resp}, {LW{1'b0}});
        chk("spur_dresp", {255'd0, bus.dcache_resp}, {LW{1'b0}});
        tick();
        bus.pmem_resp = 1'b0;
        #1;
        chk("spur_strobes", {254'd0, bus.pmem_read, bus.pmem_write}, {LW{1'b0}});

        // rst and pmem_resp together: resp still passes, then IDLE
        bus.icache_read    = 1'b1;
        bus.icache_address = 32'h0000_0600;
        tick();
        chk("rr_strobe", {255'd0, bus.pmem_read}, {{255{1'b0}}, 1'b1});
        chk("rr_addr", {224'd0, bus.pmem_address}, {224'd0, 32'h0000_0600});
        bus.icache_read = 1'b0;
        rst             = 1'b1;
        bus.pmem_resp   = 1'b1;
        bus.pmem_rdata  = pat_db;
        #1;
        chk("rr_iresp", {255'd0, bus.icache_resp}, {{255{1'b0}}, 1'b1});
        chk("rr_dresp", {255'd0, bus.dcache_resp}, {LW{1'b0}});
        chk("rr_irdata", bus.icache_rdata, pat_db);
        tick();
        rst           = 1'b0;
        bus.pmem_resp = 1'b0;
        #1;
        chk("rr_strobes", {254'd0, bus.pmem_read, bus.pmem_write}, {LW{1'b0}});
        chk("sb_drained", sb.size(), {LW{1'b0}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
# cache_arbiter

Two-port memory arbiter between the instruction cache and the data cache of the pipelined RV32I core. It owns the single physical-memory/cacheline-adaptor port and grants it to one cache at a time. Arbitration is round-robin. Each grant latches the request and holds it stable on the memory side until the memory responds, then returns the line and response to the winning cache only. While a cache waits, the pipeline holds through the existing IF_stall/MA_stall paths.

## Interface
Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, byte address width

Ports:
- clk  in  1  sole clock, all state on posedge
- rst  in  1  synchronous, active-high reset
- icache_read  in  1  I-cache line-fill request
- icache_address  in  ADDR_W  I-cache line address
- icache_rdata  out  LINE_W  fill data to I-cache
- icache_resp  out  1  one-cycle completion pulse to I-cache
- dcache_read  in  1  D-cache line-fill request
- dcache_write  in  1  D-cache write-back request
- dcache_address  in  ADDR_W  D-cache line address
- dcache_wdata  in  LINE_W  write-back data
- dcache_rdata  out  LINE_W  fill data to D-cache
- dcache_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read strobe, level, held until pmem_resp
- pmem_write  out  1  memory write strobe, level, held until pmem_resp
- pmem_address  out  ADDR_W  latched address
- pmem_wdata  out  LINE_W  latched write data
- pmem_rdata  in  LINE_W  memory read data, valid with pmem_resp
- pmem_resp  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY. Reset state is IDLE.
- Priority register last_d is 1 when the D-cache was served last. Reset value is 0, so the D-cache wins the first contention.
- Grant in IDLE:
  - only I requesting: grant I.
  - only D requesting (read or write): grant D.
  - both requesting: grant D if last_d=0, else grant I.
- Granting means:
  - latch address, wdata and op (read/write) into holding registers.
  - go to the BUSY state.
  - update last_d.
- D-cache op select: dcache_write=1 selects a write. dcache_read and dcache_write both high is illegal; write takes precedence and the read is ignored.
- In BUSY:
  - pmem_read or pmem_write is driven from the latched op. pmem_address and pmem_wdata are driven from the holding registers.
  - Cache inputs are ignored, so a requester dropping or changing its request mid-transaction does not affect memory.
- On pmem_resp in BUSY:
  - assert resp to the owner in the same cycle (combinational).
  - route pmem_rdata to the owner's rdata in the same cycle.
  - next state is IDLE.
- icache_rdata and dcache_rdata always show pmem_rdata. Only the matching resp qualifies them.
- A resp is never asserted to the non-owner.
- pmem_resp in IDLE is spurious and ignored.

## Timing
- All outputs are 0 after reset: pmem_read, pmem_write, pmem_address, pmem_wdata, icache_resp, dcache_resp. Holding registers are also 0.
- Request to strobe latency:
  - request seen in IDLE at edge N.
  - pmem strobe high in cycle N+1 (registered state decode).
- Response cycle:
  - pmem_resp high in cycle M means cache resp is high in cycle M.
  - strobe is 0 in cycle M+1.
  - state is IDLE in cycle M+1.
- One mandatory IDLE cycle separates transactions. Back-to-back grants start at M+1 and the next strobe appears at M+2.
- Caches must hold their request high until they see resp. A request still high in the IDLE cycle after its own resp is treated as a new request, so caches must deassert in cycle M+1.
- Fairness: with both caches continuously requesting, grants strictly alternate. Worst-case wait is one full foreign transaction plus one IDLE cycle.
- Reset mid-transaction: rst at any edge forces IDLE and clears the strobes next cycle. No resp is emitted for the aborted transaction.
- rst and pmem_resp in the same cycle: resp still passes through combinationally that cycle, and the state goes IDLE.

## Test plan
- I-only fill: icache_read=1, address 0x0000_1000. pmem_read rises one cycle later with pmem_address 0x1000. pmem_resp with rdata 0xA5…A5 gives icache_resp=1 and icache_rdata=0xA5…A5 in that same cycle. dcache_resp stays 0 throughout.
- Simultaneous requests after reset:
  - icache_read=1 @0x100 and dcache_read=1 @0x200 together. D is served first at 0x200; I is served next at 0x100 after one IDLE cycle.
  - repeat with both requests still asserted. Grant order is D, I, D, I.
- D write-back: dcache_write=1, address 0x8000, wdata 0xDEAD…BEEF. pmem_write=1, pmem_read=0, pmem_wdata matches. dcache_resp fires on pmem_resp.
- Input change mid-transaction: after the I grant, change icache_address to 0xFFFF_FFC0 and drop icache_read. pmem_address stays 0x100 until pmem_resp.
- Reset mid-transaction: pulse rst two cycles into a D read. Both strobes are 0 on the next cycle and no dcache_resp is emitted. The next contention grants D first.
- Illegal D op: dcache_read=1 and dcache_write=1 together. A write is issued (pmem_write=1, pmem_read=0).
